// File: rtl/seq_pkg.sv
// Shared types for the training sample sequencer: state encoding and default widths.
package seq_pkg;

  localparam int DATA_W_DEF = 48;
  localparam int IDX_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_IN  = 3'd1,
    ST_LOAD_LBL = 3'd2,
    ST_LOC_RST  = 3'd3,
    ST_RUN      = 3'd4
  } seq_state_e;

  function automatic logic is_load(input seq_state_e s);
    return (s == ST_LOAD_IN) || (s == ST_LOAD_LBL);
  endfunction

endpackage

// File: rtl/seq_row_counter.sv
// Row counter for the storage write path; flags when the current row is the terminal row.
module seq_row_counter #(
  parameter int W = 32
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         last
);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)    count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= count + W'(1);
  end

  assign last = (count == term);

endmodule

// File: rtl/sample_sequencer.sv
// Per-sample training sequencer: streams input and label vectors into storage,
// pulses the locator reset, then runs the controller until done, num_samples times.
module sample_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int IN_ROWS     = 4,
  parameter int LBL_ROWS    = 2,
  parameter int RUN_TIMEOUT = 4096
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W-1:0]  num_samples,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              in_is_write,
  output logic [IDX_W-1:0]  in_layer_index,
  output logic [IDX_W-1:0]  in_row_index,
  output logic [DATA_W-1:0] in_write_data,
  output logic              lbl_is_write,
  output logic [IDX_W-1:0]  lbl_layer_index,
  output logic [IDX_W-1:0]  lbl_row_index,
  output logic [DATA_W-1:0] lbl_write_data,
  output logic              locator_reset,
  output logic              controller_enable,
  input  logic              run_done,
  output logic              busy,
  output logic [IDX_W-1:0]  sample_count,
  output logic              epoch_done,
  output logic              timeout_err
);

  localparam int               RUN_W    = $clog2(RUN_TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_TIMEOUT - 1);

  logic       gclk;
  logic       grst_n;
  logic [1:0] rst_sync;

  assign gclk = clk_clk;

  // Reset asserts immediately but releases two clocks later, in sync with gclk.
  always_ff @(posedge gclk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_sync <= 2'b00;
    else                rst_sync <= {rst_sync[0], 1'b1};
  end
  assign grst_n = rst_sync[1];

  seq_state_e       state, state_nxt;
  logic [IDX_W-1:0] num_lat, row, row_term, cnt_inc;
  logic [RUN_W-1:0] run_cnt;
  logic             load, hs, row_last, row_clr;
  logic             start_ok, zero_epoch, in_run, done_hit, epoch_hit, tmo_hit;

  assign load       = is_load(state);
  assign hs         = s_valid & load;
  assign in_run     = (state == ST_RUN);
  assign start_ok   = (state == ST_IDLE) & start & ~abort;
  assign zero_epoch = start_ok & (num_samples == '0);
  assign cnt_inc    = sample_count + IDX_W'(1);
  assign done_hit   = in_run & run_done & ~abort;
  assign epoch_hit  = done_hit & (cnt_inc == num_lat);
  assign tmo_hit    = in_run & ~run_done & ~abort & (run_cnt == RUN_LAST);
  assign row_term   = (state == ST_LOAD_LBL) ? IDX_W'(LBL_ROWS - 1) : IDX_W'(IN_ROWS - 1);
  assign row_clr    = ~load | abort | (hs & row_last);

  seq_row_counter #(.W(IDX_W)) u_row (
    .gclk   (gclk),
    .grst_n (grst_n),
    .clear  (row_clr),
    .inc    (hs),
    .term   (row_term),
    .count  (row),
    .last   (row_last)
  );

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (start && num_samples != '0) state_nxt = ST_LOAD_IN;
        ST_LOAD_IN:  if (hs && row_last)             state_nxt = ST_LOAD_LBL;
        ST_LOAD_LBL: if (hs && row_last)             state_nxt = ST_LOC_RST;
        ST_LOC_RST:                                  state_nxt = ST_RUN;
        ST_RUN: begin
          if (run_done)                  state_nxt = epoch_hit ? ST_IDLE : ST_LOAD_IN;
          else if (run_cnt == RUN_LAST)  state_nxt = ST_IDLE;
        end
        default:                                     state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_ready           = load;
    in_is_write       = hs & (state == ST_LOAD_IN);
    lbl_is_write      = hs & (state == ST_LOAD_LBL);
    in_layer_index    = '0;
    lbl_layer_index   = '0;
    in_row_index      = row;
    lbl_row_index     = row;
    in_write_data     = load ? s_data : '0;
    lbl_write_data    = load ? s_data : '0;
    locator_reset     = (state == ST_LOC_RST);
    controller_enable = in_run;
    busy              = (state != ST_IDLE);
  end

  // run_done beats the timeout in the same cycle; abort beats both.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      num_lat      <= '0;
      sample_count <= '0;
      timeout_err  <= 1'b0;
      epoch_done   <= 1'b0;
      run_cnt      <= '0;
    end else begin
      epoch_done <= zero_epoch | epoch_hit;
      run_cnt    <= in_run ? run_cnt + RUN_W'(1) : '0;
      if (start_ok) begin
        num_lat      <= num_samples;
        sample_count <= '0;
        timeout_err  <= 1'b0;
      end
      if (done_hit) sample_count <= cnt_inc;
      if (tmo_hit)  timeout_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: per-cycle behavioural model plus directed epoch scenarios.
module tb_sample_sequencer;

  localparam int DW  = 48;
  localparam int IW  = 32;
  localparam int INR = 4;
  localparam int LBR = 2;
  localparam int RTO = 8;
  localparam int WPS = INR + LBR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0, run_done = 1'b0;
  logic [IW-1:0] num_samples = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, in_is_write, lbl_is_write, locator_reset, controller_enable;
  logic          busy, epoch_done, timeout_err;
  logic [IW-1:0] in_layer_index, in_row_index, lbl_layer_index, lbl_row_index, sample_count;
  logic [DW-1:0] in_write_data, lbl_write_data;

  always #5 clk = ~clk;

  sample_sequencer #(
    .DATA_W(DW), .IDX_W(IW), .IN_ROWS(INR), .LBL_ROWS(LBR), .RUN_TIMEOUT(RTO)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .abort(abort),
    .num_samples(num_samples), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .in_is_write(in_is_write), .in_layer_index(in_layer_index),
    .in_row_index(in_row_index), .in_write_data(in_write_data),
    .lbl_is_write(lbl_is_write), .lbl_layer_index(lbl_layer_index),
    .lbl_row_index(lbl_row_index), .lbl_write_data(lbl_write_data),
    .locator_reset(locator_reset), .controller_enable(controller_enable),
    .run_done(run_done), .busy(busy), .sample_count(sample_count),
    .epoch_done(epoch_done), .timeout_err(timeout_err)
  );

  typedef struct {bit lbl; int row; logic [DW-1:0] data;} wr_t;
  wr_t           exp_q[$];
  logic [DW-1:0] host_q[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_cnt, m_num, m_run;
  bit m_epoch, m_tmo, m_loc_prev, m_abort_prev;
  int n_in = 0, n_lbl = 0, n_loc = 0, n_en = 0, n_epoch = 0, n_busy = 0;
  int b_in, b_lbl, b_loc, b_en, b_epoch, b_busy;
  bit ended, hit;
  int run_delay, done_limit, given, en_drv, dur, c0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_num = 0; m_run = 0; m_epoch = 0; m_tmo = 0;
    m_loc_prev = 0; m_abort_prev = 0; en_drv = 0;
  endtask

  task automatic snap();
    b_in = n_in; b_lbl = n_lbl; b_loc = n_loc; b_en = n_en; b_epoch = n_epoch; b_busy = n_busy;
  endtask

  task automatic push_words(input int n_samp);
    for (int s = 0; s < n_samp; s++) begin
      for (int k = 0; k < WPS; k++) begin
        logic [DW-1:0] d;
        wr_t w;
        d = {16'(s * 16 + k), $urandom()};
        host_q.push_back(d);
        w.lbl = (k >= INR); w.row = (k < INR) ? k : k - INR; w.data = d;
        exp_q.push_back(w);
      end
    end
  endtask

  // Model: writes follow the host word order; counters follow the epoch rules.
  task automatic compare();
    wr_t w;
    bit acc, ep_n;
    chk("in_layer", in_layer_index, 0);
    chk("lbl_layer", lbl_layer_index, 0);
    chk("wr_strobe", in_is_write | lbl_is_write, s_valid & s_ready);
    chk("wr_excl", in_is_write & lbl_is_write, 0);
    if (in_is_write || lbl_is_write) begin
      chk("wr_queue_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("wr_target", lbl_is_write, w.lbl);
        chk("wr_row", w.lbl ? lbl_row_index : in_row_index, w.row);
        chk("wr_data", w.lbl ? lbl_write_data : in_write_data, w.data);
      end
    end
    chk("sample_count", sample_count, m_cnt);
    chk("epoch_done", epoch_done, m_epoch);
    chk("timeout_err", timeout_err, m_tmo);
    chk("idle_quiet", ~busy & (s_ready | controller_enable | locator_reset), 0);
    if (m_loc_prev)   chk("loc_then_run", {locator_reset, controller_enable}, 2'b01);
    if (m_abort_prev) chk("abort_quiet", {busy, s_ready, controller_enable, locator_reset}, 0);
    m_loc_prev   = locator_reset && !abort;
    m_abort_prev = abort;
    n_in += in_is_write; n_lbl += lbl_is_write; n_loc += locator_reset;
    n_en += controller_enable; n_epoch += epoch_done; n_busy += busy;
    if (epoch_done || timeout_err) ended = 1;
    if (s_valid && s_ready && host_q.size() != 0) void'(host_q.pop_front());
    m_run = controller_enable ? m_run + 1 : 0;
    acc   = start && !busy && !abort;
    ep_n  = 0;
    if (!abort) begin
      if (acc) begin
        m_cnt = 0; m_tmo = 0; m_num = int'(num_samples); ep_n = (num_samples == 0);
      end else if (controller_enable && run_done) begin
        m_cnt++; ep_n = (m_cnt == m_num);
      end else if (controller_enable && m_run == RTO) begin
        m_tmo = 1;
      end
    end
    m_epoch = ep_n;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  // Host and controller stand-ins for the coming cycle.
  task automatic drive(input bit tog, input int c);
    en_drv   = controller_enable ? en_drv + 1 : 0;
    run_done = (run_delay != 0) && (en_drv == run_delay) && (given < done_limit);
    if (run_done) given++;
    s_valid  = (host_q.size() != 0) && (!tog || ((cyc - c) % 2 == 1));
    s_data   = (host_q.size() != 0) ? host_q[0] : '0;
  endtask

  task automatic run_epoch(input int num, input int delay, input int limit, input bit tog,
                           output int d);
    int c;
    run_delay = delay; done_limit = limit; given = 0; en_drv = 0;
    c = cyc; num_samples = IW'(num); start = 1;
    drive(tog, c); step(); start = 0; ended = 0; d = -1;
    for (int i = 0; i < 200 && !ended; i++) begin drive(tog, c); step(); end
    if (ended) d = cyc - 1 - c;
    else chk("epoch_wait", ended, 1);
    s_valid = 0; run_done = 0;
  endtask

  task automatic release_reset();
    @(posedge clk); #1 rst_n = 1;
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enable", controller_enable, 0);
    chk("rst_locator", locator_reset, 0);
    chk("rst_writes", {in_is_write, lbl_is_write}, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_flags", {epoch_done, timeout_err}, 0);
    model_reset();
    release_reset();

    // Two samples, continuous stream, run_done on the third RUN cycle.
    snap(); push_words(2); run_epoch(2, 3, 2, 0, dur);
    chk("t2_dur", dur, 21);
    chk("t2_in_writes", n_in - b_in, 8);
    chk("t2_lbl_writes", n_lbl - b_lbl, 4);
    chk("t2_locator", n_loc - b_loc, 2);
    chk("t2_enable", n_en - b_en, 6);
    chk("t2_epoch", n_epoch - b_epoch, 1);
    chk("t2_count", sample_count, 2);
    chk("t2_busy", busy, 0);
    chk("t2_drained", exp_q.size(), 0);

    // Stream valid every other cycle.
    snap(); push_words(1); run_epoch(1, 3, 1, 1, dur);
    chk("t3_dur", dur, 16);
    chk("t3_in_writes", n_in - b_in, 4);
    chk("t3_lbl_writes", n_lbl - b_lbl, 2);
    chk("t3_count", sample_count, 1);
    chk("t3_drained", exp_q.size(), 0);

    // First sample completes, second times out.
    snap(); push_words(3); run_epoch(3, 3, 1, 0, dur);
    chk("t4_dur", dur, 26);
    chk("t4_timeout", timeout_err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_count_held", sample_count, 1);
    chk("t4_enable", n_en - b_en, 11);
    chk("t4_epoch", n_epoch - b_epoch, 0);
    chk("t4_leftover", host_q.size(), 6);
    host_q.delete(); exp_q.delete();

    // Zero samples: immediate epoch_done, nothing else.
    snap(); run_epoch(0, 3, 1, 0, dur);
    chk("t5_dur", dur, 1);
    chk("t5_quiet", (n_in - b_in) + (n_lbl - b_lbl) + (n_loc - b_loc) + (n_en - b_en), 0);
    chk("t5_busy_cycles", n_busy - b_busy, 0);
    chk("t5_timeout_clr", timeout_err, 0);
    chk("t5_epoch", n_epoch - b_epoch, 1);

    // Abort together with run_done in the second sample's RUN.
    snap(); push_words(2);
    run_delay = 3; done_limit = 1; given = 0; en_drv = 0;
    c0 = cyc; num_samples = 2; start = 1; drive(0, c0); step(); start = 0; hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin
      drive(0, c0);
      if (controller_enable && sample_count == 1 && en_drv == 2) begin
        run_done = 1; abort = 1; hit = 1;
      end
      step(); abort = 0; run_done = 0;
    end
    chk("t6_reached", hit, 1);
    s_valid = 0;
    repeat (3) step();
    chk("t6_busy", busy, 0);
    chk("t6_count_held", sample_count, 1);
    chk("t6_epoch", n_epoch - b_epoch, 0);
    chk("t6_locator", n_loc - b_loc, 2);
    chk("t6_drained", exp_q.size(), 0);

    // Reset asserted mid-RUN drops outputs in the same cycle.
    push_words(1);
    run_delay = 0; done_limit = 0; given = 0; en_drv = 0;
    c0 = cyc; num_samples = 1; start = 1; drive(0, c0); step(); start = 0; hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin drive(0, c0); step(); hit = controller_enable; end
    drive(0, c0); step();
    chk("t1_in_run", controller_enable, 1);
    rst_n = 0; s_valid = 0;
    #1;
    chk("t1_enable", controller_enable, 0);
    chk("t1_busy", busy, 0);
    chk("t1_s_ready", s_ready, 0);
    chk("t1_count", sample_count, 0);
    host_q.delete(); exp_q.delete();
    model_reset();
    release_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
